// File: rtl/rv32i_pkg.sv
// ============================================================================
// Module      : rv32i_pkg
// Description : Types and constants shared by the rv32I fetch and decode stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
// ============================================================================
// Module      : pc_next
// Description : Next-PC selection (reset/redirect/+4/hold) and alignment check.
//               Trapping of misaligned redirects is enabled by FETCH_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic  reset,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  input  logic  advance,
  input  addr_t pc,
  output addr_t next_pc,
  output logic  misaligned
);

  always_comb begin
    next_pc    = pc;
    misaligned = 1'b0;
    if (reset) begin
      next_pc = RESET_PC;
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // A misaligned target is refused: the PC keeps its pre-redirect value.
      if (redirect_pc[1:0] != 2'b00) begin
        misaligned = 1'b1;
      end else begin
        next_pc = redirect_pc;
      end
`else
      next_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else if (advance) begin
      next_pc = pc + INSTR_BYTES;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : rv32I instruction fetch: PC register, IF/ID register, redirects.
//               Optional macro: FETCH_MISALIGN_TRAP_EN (trap misaligned redirects).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr,
  output logic        fetch_misaligned
);

  addr_t  r_pc;
  if_id_t r_if_id;
  logic   r_misaligned;
  addr_t  w_next_pc;
  logic   w_misaligned;
  logic   w_advance;

  assign w_advance = !r_if_id.valid || id_ready;

  pc_next #(
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (w_advance),
    .pc             (r_pc),
    .next_pc        (w_next_pc),
    .misaligned     (w_misaligned)
  );

  always_ff @(posedge clk) begin
    r_pc <= w_next_pc;
    if (reset) begin
      r_if_id      <= '0;
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      // Flush the in-flight fetch even if decode is stalled.
      r_if_id.valid <= 1'b0;
      r_misaligned  <= w_misaligned;
    end else begin
      r_misaligned <= 1'b0;
      if (w_advance) begin
        r_if_id.valid    <= 1'b1;
        r_if_id.pc       <= r_pc;
        r_if_id.pc_plus4 <= r_pc + INSTR_BYTES;
        r_if_id.instr    <= imem_instr;
      end
    end
  end

  assign imem_addr        = r_pc;
  assign id_valid         = r_if_id.valid;
  assign id_pc            = r_if_id.pc;
  assign id_pc_plus4      = r_if_id.pc_plus4;
  assign id_instr         = r_if_id.instr;
  assign fetch_misaligned = r_misaligned;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the rv32I core, directly upstream of `instruction_memory`. It owns the program counter and drives the memory's `read_address`. It captures the returned instruction into an IF/ID pipeline register and hands it to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute, with optional misaligned-target trapping.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word aligned.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `imem_addr`, output, 32: to `instruction_memory.read_address`; always equal to the PC register; always word aligned.
- `imem_instr`, input, 32: from `instruction_memory.instruction`; combinational read of `imem_addr`.
- `redirect_valid`, input, 1: execute requests a PC change this cycle.
- `redirect_pc`, input, 32: branch/jump target.
- `id_ready`, input, 1: decode can accept the IF/ID contents this cycle.
- `id_valid`, output, 1: IF/ID register holds a live instruction.
- `id_pc`, output, 32: PC of the instruction in IF/ID.
- `id_pc_plus4`, output, 32: `id_pc + 4`, modulo 2^32.
- `id_instr`, output, 32: instruction word in IF/ID.
- `fetch_misaligned`, output, 1: one-cycle pulse when a misaligned redirect is trapped (macro only; tied 0 otherwise).

## Operation
- State: PC register, IF/ID register (`id_valid`, `id_pc`, `id_pc_plus4`, `id_instr`), and the `fetch_misaligned` flop.
- Reset, evaluated at the edge while `reset`=1: PC<=`RESET_PC`; `id_valid`, `id_pc`, `id_pc_plus4`, `id_instr`, `fetch_misaligned` <= 0. Reset overrides redirect and handshake.
- Define `advance` = `!id_valid || id_ready`.
- Priority at each edge, highest first:
  1. reset.
  2. Redirect (`redirect_valid`=1): PC<=target; `id_valid`<=0. The in-flight fetch is flushed regardless of `id_ready`.
  3. Advance: IF/ID <= {1, PC, PC+4, `imem_instr`}; PC<=PC+4.
  4. Hold: PC and IF/ID unchanged.
- PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. No range checking against memory depth.
- Handshake: a transfer to decode occurs on an edge where `id_valid`=1 and `id_ready`=1. While `id_valid`=1 and `id_ready`=0, all `id_*` outputs are stable. `id_ready` may be high while `id_valid`=0, which is a no-op.

## Timing
- `imem_addr` is purely registered: PC flop to port, no combinational path from any input.
- Fetch latency is 1 cycle: the instruction at PC P appears on `id_*` the cycle after `imem_addr`=P.
- After reset deasserts, `id_valid`=1 with `id_pc`=`RESET_PC` one cycle later. Throughput is 1 instruction per cycle when `id_ready` is held at 1.
- Redirect penalty: a redirect sampled at edge N gives `imem_addr`=target in cycle N+1, `id_valid`=0 in cycle N+1, and the target instruction valid in cycle N+2. This is one bubble.
- Redirect and `id_ready`=0 in the same cycle: the redirect wins and the held instruction is dropped.
- Back-to-back redirects: each one overrides the previous; only the last target is fetched.
- Reset asserted mid-stream: all state clears at that edge, with no partial transfer.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]`!=0 does not update the PC.
  - `id_valid`<=0 (flush still occurs).
  - `fetch_misaligned`<=1 for exactly one cycle.
  - The PC holds its pre-redirect value.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - `redirect_pc[1:0]` is ignored and the PC is loaded with `{redirect_pc[31:2],2'b00}`.
  - `fetch_misaligned` is constant 0.

## Structure
- Shared package `rv32i_pkg` holds:
  - constant `INSTR_BYTES`=4;
  - typedef `if_id_t` struct {`logic valid; logic [31:0] pc, pc_plus4, instr;`}, reused by decode;
  - typedef `addr_t` = `logic [31:0]`.
- One natural sub-module, `pc_next`: combinational next-PC selection (reset / redirect / +4 / hold) plus the alignment check. The PC and IF/ID flops stay in `fetch_unit`.

## Test plan
- Reset release, `RESET_PC`=0x100, `id_ready`=1 -> `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles. `id_valid` first rises one cycle after reset, with `id_pc`=0x100 and `id_pc_plus4`=0x104.
- Stall: hold `id_ready`=0 for 3 cycles while `id_valid`=1, `id_pc`=0x8 -> `id_*` and `imem_addr`=0xC are unchanged. On `id_ready`=1, `id_pc`=0xC follows the next cycle.
- Redirect to 0x40 while stalled -> `id_valid`=0 the next cycle with `imem_addr`=0x40. The cycle after that, `id_valid`=1 and `id_pc`=0x40.
- PC wrap: redirect to 0xFFFF_FFFC -> following fetch has `id_pc`=0xFFFF_FFFC and `id_pc_plus4`=0x0, then `id_pc`=0x0.
- Misaligned redirect to 0x42:
  - with `FETCH_MISALIGN_TRAP_EN`: one-cycle `fetch_misaligned`=1, `id_valid`=0, PC unchanged;
  - without it: the next `id_pc`=0x40 and `fetch_misaligned`=0.
- Reset asserted during a stall with `id_valid`=1 -> the next cycle has all outputs 0 and `imem_addr`=`RESET_PC`, regardless of `redirect_valid`.
